bcd_counter_3d: RTL and testbench

//   Three-digit BCD event/seconds counter that feeds the 7-segment scan driver (D7S).
//   - Prescaler turns clk into a periodic count tick.
//   - Counter holds 000..999 as three packed BCD nibbles; the display stage scans them out.
//   - Provides load, clear and enable controls, plus update and wrap strobes.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit.sv | 43 ++++
 rtl/bcd_counter_3d.sv | 98 +++++++++
 tb/tb_bcd_counter_3d.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the three-digit BCD counter.
//   BCD_MAX   largest legal BCD digit value
//   BCD_W     width of one BCD digit
//   NDIG      number of digits in the counter
//   bcd_clamp saturates a nibble to the BCD range (min(x, 9))
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         BCD_W   = 4;
  localparam int         NDIG    = 3;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [3:0] x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of a chained up/down counter.
// Ports:
//   clk     system clock, posedge
//   rst     synchronous reset, active-high (q -> 0)
//   clr     synchronous clear (q -> 0)
//   load    load the clamped load_d into q
//   load_d  digit value to load; nibbles above 9 load as 9
//   step    advance one BCD step this cycle
//   up      1 = increment, 0 = decrement
//   q       registered digit value, always 0..9
//   co      combinational carry/borrow: step and q at its roll-over value
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  input  logic             step,
  input  logic             up,
  output logic [BCD_W-1:0] q,
  output logic             co
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= bcd_clamp(load_d);
    end else if (step) begin
      if (up) q <= (q == BCD_MAX) ? '0 : q + 4'd1;
      else    q <= (q == '0) ? BCD_MAX : q - 4'd1;
    end
  end

  always_comb begin
    co = step & (up ? (q == BCD_MAX) : (q == '0));
  end

endmodule

// File: rtl/bcd_counter_3d.sv
// Three-digit BCD event/seconds counter (000..999) feeding the 7-segment
// scan driver. A prescaler produces one count tick every PRESCALE enabled
// clock cycles; the count steps one cycle after the tick.
// Optional feature macro: BCD_CNT_UPDOWN_EN (up/down counting via up_dn).
// Ports:
//   clk       system clock, posedge
//   rst       synchronous reset, active-high
//   en        1 = prescaler runs; 0 = prescaler frozen, no ticks
//   clr       synchronous clear of count and prescaler
//   load      load load_val (nibbles clamped to 9), clear prescaler
//   load_val  {hundreds,tens,units} BCD value to load
//   up_dn     count direction (only with BCD_CNT_UPDOWN_EN)
//   digits    {hundreds,tens,units}, registered
//   upd       1-cycle pulse when a new digits value first appears
//   wrap      1-cycle pulse when digits rolls 999->000 (or 000->999 down)
//   tick      1-cycle prescaler tick
module bcd_counter_3d
  import bcd_pkg::*;
#(
  parameter int PRESCALE = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        up_dn,
  output logic [11:0] digits,
  output logic        upd,
  output logic        wrap,
  output logic        tick
);

  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0]  ps;
  logic [NDIG-1:0]  step;
  logic [NDIG-1:0]  co;
  logic             dir;

`ifdef BCD_CNT_UPDOWN_EN
  assign dir = up_dn;
`else
  logic _unused;
  assign dir     = 1'b1;
  assign _unused = up_dn;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr || load) begin
      ps   <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (ps == PS_W'(PRESCALE - 1)) begin
        ps   <= '0;
        tick <= 1'b1;
      end else begin
        ps   <= ps + PS_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Ripple chain: each digit steps on the carry/borrow of the digit below.
  assign step[0] = tick;
  for (genvar i = 1; i < NDIG; i++) begin : g_chain
    assign step[i] = co[i-1];
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .load   (load),
      .load_d (load_val[i*BCD_W +: BCD_W]),
      .step   (step[i]),
      .up     (dir),
      .q      (digits[i*BCD_W +: BCD_W]),
      .co     (co[i])
    );
  end

  // clr/load override a coincident tick, so its carry must not raise wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      upd  <= clr | load | tick;
      wrap <= ~clr & ~load & co[NDIG-1];
    end
  end

endmodule

// File: tb/tb_bcd_counter_3d.sv
// Self-checking bench for bcd_counter_3d (PRESCALE=4): directed scenarios
// followed by randomized control traffic, checked against a decimal model.
module tb_bcd_counter_3d;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst, en, clr, load, up_dn;
  logic [11:0] load_val;
  logic [11:0] digits;
  logic        upd, wrap, tick;

  bcd_counter_3d #(.PRESCALE(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .up_dn    (up_dn),
    .digits   (digits),
    .upd      (upd),
    .wrap     (wrap),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state: count held as a plain decimal integer
  int m_val, m_ps;
  bit m_tick, m_upd, m_wrap;

  task automatic check_eq(input string tag, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int clamp_val(input logic [11:0] v);
    int h, t, u;
    h = int'(v[11:8]); t = int'(v[7:4]); u = int'(v[3:0]);
    if (h > 9) h = 9;
    if (t > 9) t = 9;
    if (u > 9) u = 9;
    return h * 100 + t * 10 + u;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100); t = 4'((v / 10) % 10); u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic model_edge();
    bit up;
`ifdef BCD_CNT_UPDOWN_EN
    up = up_dn;
`else
    up = 1'b1;
`endif
    if (rst) begin
      m_val = 0; m_ps = 0; m_tick = 0; m_upd = 0; m_wrap = 0;
    end else if (clr || load) begin
      m_val  = clr ? 0 : clamp_val(load_val);
      m_ps   = 0; m_tick = 0; m_upd = 1; m_wrap = 0;
    end else begin
      m_upd = m_tick; m_wrap = 0;
      if (m_tick) begin
        if (up) begin m_wrap = (m_val == 999); m_val = (m_val + 1) % 1000; end
        else    begin m_wrap = (m_val == 0);   m_val = (m_val + 999) % 1000; end
      end
      if (en) begin
        if (m_ps == P - 1) begin m_ps = 0; m_tick = 1; end
        else begin m_ps = m_ps + 1; m_tick = 0; end
      end else begin
        m_tick = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("digits", digits, to_bcd(m_val));
    check_eq("upd",    {11'd0, upd},  {11'd0, m_upd});
    check_eq("wrap",   {11'd0, wrap}, {11'd0, m_wrap});
    check_eq("tick",   {11'd0, tick}, {11'd0, m_tick});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1; load_val = v; cyc(); load = 0;
  endtask

  // advance until the model reaches prescaler value ps (bounded)
  task automatic run_to_ps(input int ps, input string tag);
    int k;
    k = 0;
    while (m_ps != ps && k < 4 * P) begin cyc(); k++; end
    if (m_ps != ps) begin
      n_checks++; n_fails++;
      $display("FAIL %s: prescaler target %0d not reached", tag, ps);
    end
  endtask

  task automatic run_to_tick(input string tag);
    int k;
    k = 0;
    while (!m_tick && k < 4 * P) begin cyc(); k++; end
    if (!m_tick) begin
      n_checks++; n_fails++;
      $display("FAIL %s: no tick within budget", tag);
    end
  endtask

  initial begin
    rst = 1; en = 1; clr = 0; load = 0; load_val = '0; up_dn = 1;
    m_val = 0; m_ps = 0; m_tick = 0; m_upd = 0; m_wrap = 0;

    // reset, then free-running up count
    cycles(2);
    check_eq("reset_digits", digits, 12'h000);
    rst = 0;
    cycles(14);
    check_eq("count_after_14", digits, 12'h003);

    // roll-over 998 -> 999 -> 000 with wrap
    do_load(12'h998);
    check_eq("load_998", digits, 12'h998);
    cycles(10);
    check_eq("wrapped_000", digits, 12'h000);

    // clamped load
    do_load(12'hFA7);
    check_eq("load_clamp", digits, 12'h997);
    cycles(6);

    // freeze at ps=2 for 10 cycles, then resume
    run_to_ps(2, "freeze_ps");
    en = 0;
    cycles(10);
    en = 1;
    cycles(4);

    // clr coincident with tick at 045
    do_load(12'h045);
    run_to_tick("clr_tick");
    clr = 1; cyc(); clr = 0;
    check_eq("clr_over_tick", digits, 12'h000);
    cycles(3);

    // reset mid-count
    run_to_ps(2, "rst_mid");
    rst = 1; cyc(); rst = 0;
    check_eq("rst_mid_digits", digits, 12'h000);
    cycles(6);

`ifdef BCD_CNT_UPDOWN_EN
    up_dn = 0;
    do_load(12'h100);
    cycles(10);
    check_eq("down_098", digits, 12'h098);
    do_load(12'h000);
    cycles(5);
    check_eq("down_wrap_999", digits, 12'h999);
    up_dn = 1;
`endif

    // randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      clr      = ($urandom_range(0, 79) == 0);
      load     = ($urandom_range(0, 39) == 0);
      load_val = 12'($urandom);
      en       = ($urandom_range(0, 9) != 0);
      up_dn    = 1'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
